led_status_tx: RTL and testbench
================================

# led_status_tx

Status reporter for the UART LED controller: on a request pulse it snapshots the 8-bit LED state and serialises an ASCII status line, `S=` followed by eight `0`/`1` characters and an optional CR LF, out of the FPGA UART TX pin as 8N1. It sits beside the command receiver/decoder, shares its clock, reset and baud parameters, and drives the `FPGA_TXD` pin that the receiver path leaves idle.

## Interface
- CLOCK_RATE, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 1_000_000, UART bit rate; CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (50 by default), integer ≥ 2
- i_Clock  input  1  system clock, all logic on rising edge
- i_Rst  input  1  reset, synchronous, active-high; clock i_Clock
- i_Req  input  1  status request, sampled every cycle; a single-cycle pulse is sufficient
- i_LEDs  input  8  current LED state; bit 0 = LED1
- o_TXD  output  1  UART serial out, idle high
- o_Busy  output  1  high while a frame is being transmitted
- o_Done  output  1  one-cycle pulse after the last stop bit of a frame

## Operation
- Frame: byte 0 `S` (0x53), byte 1 `=` (0x3D), bytes 2..9 = i_LEDs[7] down to i_LEDs[0], each encoded as `1` (0x31) or `0` (0x30), then optionally CR (0x0D) and LF (0x0A). N = 12 bytes with CRLF, 10 bytes without.
- Each byte is sent as a start bit (0), 8 data bits LSB first, and a stop bit (1). Consecutive bytes follow with no idle gap.
- State machine: IDLE → START → DATA (8 bits) → STOP. From STOP the machine goes to START for the next byte if byte index < N−1. Otherwise it goes to IDLE, or directly to START of a new frame if a request is pending.
- The snapshot register captures i_LEDs on the edge that starts a frame. Later changes to i_LEDs do not affect that frame.
- Pending flag (one deep): i_Req seen while o_Busy=1, including the o_Done cycle, sets the flag. Further requests collapse into it. The flag is consumed when the next frame starts.
- i_Req while idle starts a frame immediately. The pending flag is not set in that case.
- Byte index counter 0..N−1 and bit counter 0..7 reset at every frame and byte start respectively. The baud counter counts 0..CLKS_PER_BIT−1.

## Timing
- Reset values: o_TXD=1, o_Busy=0, o_Done=0. Reset also clears the pending flag, snapshot, and all counters, and puts the FSM in IDLE.
- Request at edge k in IDLE:
  - o_TXD=0 (start bit) and o_Busy=1 are visible from edge k.
  - The snapshot is taken at edge k.
- Every bit, including start and stop, holds exactly CLKS_PER_BIT cycles. One frame = N×10×CLKS_PER_BIT cycles (6000 by default with CRLF).
- At the edge ending the final stop bit, o_Done=1 for exactly one cycle and o_TXD stays 1.
  - With no pending request, o_Busy=0 from that same edge.
  - With a pending request, o_Busy stays 1, the next frame's start bit begins on that edge, and a fresh snapshot is taken.
- Request in the same cycle as o_Done is treated as pending, so the next frame starts back-to-back.
- Reset mid-frame: o_TXD=1 and o_Busy=0 on the next edge, the frame is abandoned, and no o_Done pulse is produced.
- i_Req held high continuously gives back-to-back frames with no idle gap.

## Configuration
- LED_STATUS_TX_CRLF_EN defined: N=12, each frame ends with 0x0D 0x0A.
- LED_STATUS_TX_CRLF_EN undefined: N=10, each frame ends after the i_LEDs[0] character and lasts 10×10×CLKS_PER_BIT cycles.

## Test plan
- Reset then idle 200 cycles → o_TXD=1, o_Busy=0, o_Done=0 throughout.
- i_LEDs=8'hA5, 1-cycle i_Req (CRLF_EN defined) → decoded bytes 0x53 0x3D 0x31 0x30 0x31 0x30 0x30 0x31 0x30 0x31 0x0D 0x0A. o_Done pulses exactly 6000 cycles after the request edge, and o_Busy falls on that same edge.
- Start a frame with i_LEDs=8'hFF, then change i_LEDs to 8'h00 at cycle 100 → all eight LED characters are 0x31 (snapshot held).
- Second i_Req pulse at cycle 3000 of a frame, with i_LEDs changed to 8'h01 → second frame starts on the o_Done edge with no idle gap and carries `00000001`. Three extra requests during the first frame still produce only one extra frame.
- Assert i_Rst at cycle 1234 of a frame → o_TXD=1 and o_Busy=0 next cycle, no o_Done pulse. A new request afterwards yields a complete, correct frame.
- Build without LED_STATUS_TX_CRLF_EN, i_LEDs=8'h3C → bytes `S=00111100` only, o_Done at 5000 cycles.

Source files
------------

// File: rtl/led_status_tx.sv
// Snapshots i_LEDs on request and sends "S=bbbbbbbb" (+CR LF when LED_STATUS_TX_CRLF_EN is defined) as 8N1 on o_TXD.
// Registered outputs: start bit and o_Busy appear on the request edge; one pending request is queued while busy.
module led_status_tx #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_Req,
    input  logic [7:0] i_LEDs,
    output logic       o_TXD,
    output logic       o_Busy,
    output logic       o_Done
);
    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef LED_STATUS_TX_CRLF_EN
    localparam int NUM_BYTES    = 12;
`else
    localparam int NUM_BYTES    = 10;
`endif
    localparam logic [3:0]        LAST_BYTE = 4'(NUM_BYTES - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        byte_q, byte_d;
    logic [7:0]        snap_q, snap_d;
    logic              pend_q, pend_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0] cur_byte;
    logic [2:0] led_idx;
    logic [2:0] bit_nxt;
    logic       baud_end;

    // Bytes 2..9 carry LED7 down to LED0 as ASCII '0'/'1'.
    assign led_idx = 3'(4'd9 - byte_q);
    always_comb begin
        cur_byte = 8'h53;
        case (byte_q)
            4'd0:    cur_byte = 8'h53;
            4'd1:    cur_byte = 8'h3D;
            4'd10:   cur_byte = 8'h0D;
            4'd11:   cur_byte = 8'h0A;
            default: cur_byte = {7'b0011000, snap_q[led_idx]};
        endcase
    end

    assign bit_nxt  = bit_q + 3'd1;
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        pend_d  = pend_q | (busy_q & i_Req);
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_Req) begin
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = 4'd0;
                    snap_d  = i_LEDs;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        // A queued or same-edge request chains straight into a new frame.
                        if (pend_q || i_Req) begin
                            state_d = START;
                            byte_d  = 4'd0;
                            snap_d  = i_LEDs;
                            txd_d   = 1'b0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 4'd0;
            snap_q  <= 8'h00;
            pend_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_TXD  = txd_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;
endmodule

// File: tb/tb_led_status_tx.sv
// Bench for led_status_tx: frame-time reference model checked every cycle, UART decoder for byte content.
module tb_led_status_tx;
    localparam int CPB = 50;
`ifdef LED_STATUS_TX_CRLF_EN
    localparam int N = 12;
    localparam int FRAME_LIT = 6000;
`else
    localparam int N = 10;
    localparam int FRAME_LIT = 5000;
`endif
    localparam int FRAME = N * 10 * CPB;

    logic clk = 1'b0;
    logic i_Rst, i_Req;
    logic [7:0] i_LEDs;
    logic o_TXD, o_Busy, o_Done;

    led_status_tx #(.CLOCK_RATE(50_000_000), .BAUD_RATE(1_000_000)) dut (
        .i_Clock(clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_LEDs(i_LEDs),
        .o_TXD(o_TXD), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int req_cyc, done_cyc;
    bit chk_en = 0;

    logic [7:0] A5_EXP [12] = '{8'h53, 8'h3D, 8'h31, 8'h30, 8'h31, 8'h30,
                                8'h30, 8'h31, 8'h30, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] L01_EXP [8] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31};
    logic [7:0] L96_EXP [8] = '{8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31, 8'h30};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: a frame is just a position in time; output bit follows from t.
    bit       m_act = 0, m_pend = 0, m_done = 0;
    int       m_t = 0;
    logic [7:0] m_snap = 8'h00;

    function automatic logic [7:0] frame_byte(input int bi, input logic [7:0] snap);
        if (bi == 0) return 8'h53;
        if (bi == 1) return 8'h3D;
        if (bi == 10) return 8'h0D;
        if (bi == 11) return 8'h0A;
        return snap[9 - bi] ? 8'h31 : 8'h30;
    endfunction

    function automatic logic exp_txd(input int t, input logic [7:0] snap);
        int pos, k;
        logic [7:0] b;
        pos = t / CPB;
        k   = pos % 10;
        b   = frame_byte(pos / 10, snap);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin
        if (i_Rst) begin
            m_act = 0; m_pend = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_act) begin
                if (m_t == FRAME - 1) begin
                    m_done = 1;
                    if (m_pend || i_Req) begin
                        m_t = 0; m_snap = i_LEDs; m_pend = 0;
                    end else begin
                        m_act = 0;
                    end
                end else begin
                    m_t++;
                    if (i_Req) m_pend = 1;
                end
            end else if (i_Req) begin
                m_act = 1; m_t = 0; m_snap = i_LEDs;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_txd",  o_TXD,  m_act ? exp_txd(m_t, m_snap) : 1'b1);
            chk("cyc_busy", o_Busy, m_act);
            chk("cyc_done", o_Done, m_done);
        end
        if (o_Done === 1'b1) done_cnt++;
    end

    // UART receiver: samples mid-bit, pushes each decoded byte.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    bit rx_on = 0;
    int rx_cnt = 0;
    always @(negedge clk) begin
        if (i_Rst) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (o_TXD === 1'b0) begin rx_on = 1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] = o_TXD;
                else if (rx_cnt / CPB == 9) begin rx_q.push_back(rx_sh); rx_on = 0; end
            end
        end
    end

    task automatic pulse_req();
        @(negedge clk);
        i_Req = 1'b1;
        req_cyc = cyc + 1;
        @(negedge clk);
        i_Req = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_Done === 1'b1) begin ok = 1; done_cyc = cyc; break; end
        end
    endtask

    task automatic chk_leds(input string nm, input int base, input logic [7:0] exp [8]);
        for (int i = 0; i < 8; i++)
            chk(nm, (base + 2 + i < rx_q.size()) ? rx_q[base + 2 + i] : 8'hxx, exp[i]);
    endtask

    initial begin
        bit ok;
        int bad, dc, d1;
        logic [7:0] all1 [8];
        for (int i = 0; i < 8; i++) all1[i] = 8'h31;
        i_Rst = 1'b1; i_Req = 1'b0; i_LEDs = 8'h00;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst_txd", o_TXD, 1); chk("rst_busy", o_Busy, 0); chk("rst_done", o_Done, 0);
        i_Rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_TXD !== 1'b1 || o_Busy !== 1'b0 || o_Done !== 1'b0) bad++;
        end
        chk("idle_200", bad, 0);

        // Single frame, 0xA5
        rx_q.delete(); i_LEDs = 8'hA5;
        pulse_req();
        chk("a5_start_txd", o_TXD, 0); chk("a5_start_busy", o_Busy, 1);
        wait_done(FRAME + 20, ok);
        chk("a5_done_seen", ok, 1);
        chk("a5_latency", done_cyc - req_cyc, FRAME_LIT);
        chk("a5_busy_fall", o_Busy, 0);
        chk("a5_idle_txd", o_TXD, 1);
        chk("a5_nbytes", rx_q.size(), N);
        for (int i = 0; i < N; i++) chk("a5_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, A5_EXP[i]);

        // Snapshot held while LEDs change
        rx_q.delete(); i_LEDs = 8'hFF;
        pulse_req();
        repeat (99) @(negedge clk);
        i_LEDs = 8'h00;
        wait_done(FRAME + 20, ok);
        chk("snap_done_seen", ok, 1);
        chk_leds("snap_byte", 0, all1);

        // Queued requests collapse into one extra back-to-back frame
        rx_q.delete(); i_LEDs = 8'h00;
        pulse_req();
        repeat (2999) @(negedge clk);
        i_LEDs = 8'h01;
        pulse_req();
        for (int i = 0; i < 3; i++) begin repeat (500) @(negedge clk); pulse_req(); end
        dc = done_cnt;
        wait_done(FRAME, ok);
        chk("b2b_done1", ok, 1);
        chk("b2b_busy_held", o_Busy, 1);
        chk("b2b_start_bit", o_TXD, 0);
        d1 = done_cyc;
        wait_done(FRAME + 20, ok);
        chk("b2b_done2", ok, 1);
        chk("b2b_period", done_cyc - d1, FRAME_LIT);
        repeat (300) @(negedge clk);
        chk("b2b_one_extra", done_cnt - dc, 2);
        chk("b2b_idle", o_Busy, 0);
        chk("b2b_nbytes", rx_q.size(), 2 * N);
        chk_leds("b2b_byte", N, L01_EXP);

        // Reset mid-frame
        i_LEDs = 8'h5A;
        pulse_req();
        repeat (1233) @(negedge clk);
        i_Rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd", o_TXD, 1); chk("rst_mid_busy", o_Busy, 0);
        i_Rst = 1'b0;
        dc = done_cnt;
        repeat (100) @(negedge clk);
        chk("rst_mid_nodone", done_cnt, dc);
        rx_q.delete(); i_LEDs = 8'h96;
        pulse_req();
        wait_done(FRAME + 20, ok);
        chk("rst_after_done", ok, 1);
        chk("rst_after_latency", done_cyc - req_cyc, FRAME_LIT);
        chk("rst_after_nbytes", rx_q.size(), N);
        chk_leds("rst_after_byte", 0, L96_EXP);

        // Request held high: continuous frames
        i_Req = 1'b1;
        repeat (FRAME + 100) @(negedge clk);
        i_Req = 1'b0;

        // Random requests and LED churn
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            i_Req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) i_LEDs = 8'($urandom);
        end
        i_Req = 1'b0;
        ok = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (o_Busy === 1'b0) begin ok = 1; break; end
        end
        chk("drain_idle", ok, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
